// File: rtl/stream_border_detect.sv
// Streaming 3x3 Sobel border detector: one pixel in, one thresholded pixel out, raster order.
// Define BORDER_DETECT_MAG_EN to emit the saturated gradient magnitude instead of a binary result.
module stream_border_detect #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W+2:0] threshold,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             started_q;
  logic [CW-1:0]    in_col_q, in_col_d;
  logic [RW-1:0]    in_row_q, in_row_d;
  logic [FW-1:0]    fl_cnt_q, fl_cnt_d;
  logic [CW-1:0]    out_col_q, out_col_d;
  logic [RW-1:0]    out_row_q, out_row_d;
  logic [PIX_W+2:0] thr_q, thr_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             last_q, last_d;
  // Window columns x-2 (wl) and x-1 (wm); index 0 = top row, 2 = bottom row.
  logic [PIX_W-1:0] wl_q [3];
  logic [PIX_W-1:0] wl_d [3];
  logic [PIX_W-1:0] wm_q [3];
  logic [PIX_W-1:0] wm_d [3];
  logic [PIX_W-1:0] nc   [3];
  logic [PIX_W-1:0] lb0  [IMG_W];
  logic [PIX_W-1:0] lb1  [IMG_W];

  logic             out_free, in_fire, step, emit, is_edge;
  logic [PIX_W-1:0] pix, res;
  logic signed [PIX_W+2:0] gx, gy;
  logic [PIX_W+2:0] ax, ay;
  logic [PIX_W+3:0] mag;

  function automatic logic signed [PIX_W+2:0] ext(input logic [PIX_W-1:0] p);
    return signed'({3'b000, p});
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid && ready; a producer keeps
  // valid and data stable until accepted, and ready never depends on the same-cycle valid.
  assign out_free    = !out_valid_q || out_ready;
  assign in_ready    = started_q && ((state_q == S_FILL) || (state_q == S_RUN && out_free));
  assign in_fire     = in_valid && in_ready;
  assign step        = (state_q == S_FLUSH) ? out_free : in_fire;
  assign emit        = step && (state_q != S_FILL);
  assign pix         = (state_q == S_FLUSH) ? '0 : in_data;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign frame_done  = out_valid_q && out_ready && last_q;
  assign dbg_state_o = state_q;

  always_comb begin
    nc[0] = lb1[in_col_q];
    nc[1] = lb0[in_col_q];
    nc[2] = pix;
    gx  = (ext(nc[0]) + (ext(nc[1]) <<< 1) + ext(nc[2]))
        - (ext(wl_q[0]) + (ext(wl_q[1]) <<< 1) + ext(wl_q[2]));
    gy  = (ext(wl_q[2]) + (ext(wm_q[2]) <<< 1) + ext(nc[2]))
        - (ext(wl_q[0]) + (ext(wm_q[0]) <<< 1) + ext(nc[0]));
    ax  = gx[PIX_W+2] ? unsigned'(-gx) : unsigned'(gx);
    ay  = gy[PIX_W+2] ? unsigned'(-gy) : unsigned'(gy);
    mag = {1'b0, ax} + {1'b0, ay};
`ifdef BORDER_DETECT_MAG_EN
    res = (mag > (PIX_W+4)'({PIX_W{1'b1}})) ? '1 : mag[PIX_W-1:0];
`else
    res = (mag > {1'b0, thr_q}) ? '1 : '0;
`endif
    // Masking the frame border also hides window wrap across lines and frames.
    is_edge = (out_col_q == '0) || (out_col_q == CW'(IMG_W - 1)) ||
              (out_row_q == '0) || (out_row_q == RW'(IMG_H - 1));
  end

  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    fl_cnt_d    = fl_cnt_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    thr_d       = thr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    wl_d        = wl_q;
    wm_d        = wm_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (in_fire && state_q == S_FILL && in_col_q == '0 && in_row_q == '0) thr_d = threshold;
    if (step) begin
      wl_d     = wm_q;
      wm_d     = nc;
      in_col_d = (in_col_q == CW'(IMG_W - 1)) ? '0 : in_col_q + CW'(1);
      if (state_q != S_FLUSH && in_col_q == CW'(IMG_W - 1))
        in_row_d = (in_row_q == RW'(IMG_H - 1)) ? '0 : in_row_q + RW'(1);
      case (state_q)
        S_FILL: begin
          if (in_row_q == RW'(1) && in_col_q == '0) state_d = S_RUN;
        end
        S_RUN: begin
          if (in_row_q == RW'(IMG_H - 1) && in_col_q == CW'(IMG_W - 1)) begin
            state_d  = S_FLUSH;
            fl_cnt_d = '0;
          end
        end
        S_FLUSH: begin
          fl_cnt_d = fl_cnt_q + FW'(1);
          if (fl_cnt_q == FW'(IMG_W)) begin
            state_d  = S_FILL;
            fl_cnt_d = '0;
            in_col_d = '0;
            in_row_d = '0;
          end
        end
        default: state_d = S_FILL;
      endcase
      if (emit) begin
        out_valid_d = 1'b1;
        out_data_d  = is_edge ? '0 : res;
        last_d      = (out_col_q == CW'(IMG_W - 1)) && (out_row_q == RW'(IMG_H - 1));
        out_col_d   = (out_col_q == CW'(IMG_W - 1)) ? '0 : out_col_q + CW'(1);
        if (out_col_q == CW'(IMG_W - 1))
          out_row_d = (out_row_q == RW'(IMG_H - 1)) ? '0 : out_row_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      started_q   <= 1'b0;
      in_col_q    <= '0;
      in_row_q    <= '0;
      fl_cnt_q    <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= 1'b0;
      wl_q        <= '{default: '0};
      wm_q        <= '{default: '0};
    end else begin
      state_q     <= state_d;
      started_q   <= 1'b1;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      fl_cnt_q    <= fl_cnt_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
      wl_q        <= wl_d;
      wm_q        <= wm_d;
    end
  end

  // Line buffers need no reset: stale rows only ever reach masked border outputs.
  always_ff @(posedge clk) begin
    if (step) begin
      lb1[in_col_q] <= lb0[in_col_q];
      lb0[in_col_q] <= pix;
    end
  end

endmodule

// File: tb/tb_stream_border_detect.sv
// Bench for stream_border_detect on an 8x6 frame; reference model computes Sobel per pixel
// directly from whole-frame arrays. Honours BORDER_DETECT_MAG_EN for the expected values.
module tb_stream_border_detect;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int P    = 8;
  localparam int NPIX = W * H;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [P+2:0] threshold = '0;
  logic [P-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [P-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         frame_done;
  logic [1:0]   dbg_state;

  stream_border_detect #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .threshold  (threshold),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [P-1:0] frm [NPIX];
  logic [P-1:0] stim_q [$];
  logic [P-1:0] exp_q  [$];
  int           thr_q  [$];
  int           kx [3][3];
  int           ky [3][3];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           done_cnt = 0;
  int           out_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference model: edge pixels 0, interior from the full 3x3 Sobel on the stored frame.
  task automatic add_frame(input int thr);
    int gx, gy, mag, e, p;
    for (int i = 0; i < NPIX; i++) stim_q.push_back(frm[i]);
    thr_q.push_back(thr);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) begin
          e = 0;
        end else begin
          gx = 0;
          gy = 0;
          for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
              p  = int'(frm[(y + j - 1) * W + (x + i - 1)]);
              gx += kx[j][i] * p;
              gy += ky[j][i] * p;
            end
          end
          mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef BORDER_DETECT_MAG_EN
          e = (mag > 255) ? 255 : mag;
`else
          e = (mag > thr) ? 255 : 0;
`endif
        end
        exp_q.push_back(P'(e));
      end
    end
  endtask

  task automatic fill_uniform(input logic [P-1:0] v);
    for (int i = 0; i < NPIX; i++) frm[i] = v;
  endtask

  task automatic fill_step(input bit inv);
    for (int i = 0; i < NPIX; i++) frm[i] = (((i % W) >= 4) ^ inv) ? 8'hFF : 8'h00;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) frm[i] = P'($urandom_range(255));
  endtask

  // Driver: streams stim_q, consumes outputs against exp_q; gap/bp are percentages.
  task automatic drive(input string tag, input int gap_pct, input int bp_pct, input int n_frames);
    int   in_idx = 0;
    int   total  = stim_q.size();
    int   cyc    = 0;
    bit   pend   = 1'b0;
    bit   stall_prev = 1'b0;
    logic [P-1:0] stall_data = '0;
    logic [P-1:0] e;
    done_cnt = 0;
    out_cnt  = 0;
    while ((in_idx < total || exp_q.size() > 0) && cyc < 5000) begin
      if (!pend) begin
        in_valid = (in_idx < total) && ($urandom_range(99) >= gap_pct);
        in_data  = (in_idx < total) ? stim_q[in_idx] : P'($urandom);
        if (in_idx < total && (in_idx % NPIX) == 0) threshold = (P+3)'(thr_q[in_idx / NPIX]);
        else threshold = (P+3)'($urandom_range(2047));
      end
      out_ready = ($urandom_range(99) >= bp_pct);
      @(negedge clk);
      if (stall_prev) begin
        check({tag, "_stall_valid"}, out_valid, 1);
        check({tag, "_stall_data"}, out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_output"}, out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_pix%0d", tag, out_cnt), out_data, e);
          check($sformatf("%s_done%0d", tag, out_cnt), frame_done, (out_cnt % NPIX) == NPIX - 1);
        end
        out_cnt++;
      end else begin
        check({tag, "_done_idle"}, frame_done, 0);
      end
      if (frame_done) done_cnt++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      pend = in_valid && !in_ready;
      if (in_valid && in_ready) in_idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_drain_left"}, exp_q.size(), 0);
    check({tag, "_frame_done_count"}, done_cnt, n_frames);
    stim_q.delete();
    thr_q.delete();
    exp_q.delete();
  endtask

  task automatic send_partial(input int n);
    int cnt = 0;
    int cyc = 0;
    fill_step(1'b0);
    while (cnt < n && cyc < 1000) begin
      in_valid  = 1'b1;
      in_data   = frm[cnt];
      threshold = 11'd127;
      out_ready = 1'b1;
      @(negedge clk);
      if (in_ready) cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("partial_inputs_sent", cnt, n);
  endtask

  initial begin
    kx = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    ky = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    // reset values
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    #10 rst_n = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1 check("in_ready_after_edge", in_ready, 1);

    // uniform frame, continuous
    fill_uniform(8'h80);
    add_frame(127);
    drive("uniform", 0, 0, 1);

    // vertical step, continuous
    fill_step(1'b0);
    add_frame(127);
    drive("step127", 0, 0, 1);

    // threshold boundary
    fill_step(1'b0);
    add_frame(1020);
    drive("step1020", 0, 0, 1);
    fill_step(1'b0);
    add_frame(1019);
    drive("step1019", 0, 0, 1);

    // back-pressure and input gaps
    fill_step(1'b0);
    add_frame(127);
    drive("step_bp", 35, 40, 1);

    // back-to-back frames, second inverted, valid held high
    fill_step(1'b0);
    add_frame(127);
    fill_step(1'b1);
    add_frame(127);
    drive("b2b", 0, 0, 2);

    // random content and thresholds under random stalls
    for (int f = 0; f < 3; f++) begin
      fill_random();
      add_frame($urandom_range(1300, 100));
    end
    drive("random", 25, 30, 3);

    // reset mid-frame
    send_partial(20);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_frame_done", frame_done, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("midrst_in_ready_back", in_ready, 1);
    fill_step(1'b0);
    add_frame(127);
    drive("after_rst", 10, 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_border_detect.md
# stream_border_detect

Streaming, parametrised successor to the whole-frame max-throughput border detector. It accepts one pixel per cycle in raster order over a valid/ready handshake and buffers two image lines internally. It computes a 3x3 Sobel gradient magnitude |Gx|+|Gy| per pixel and emits one thresholded output pixel per input pixel, also in raster order. It sits between the image source (file loader or camera front end) and the output frame writer, and replaces the flat 76800-entry array ports with a pixel stream.

## Interface
- IMG_W, 320: pixels per line, at least 3.
- IMG_H, 240: lines per frame, at least 3.
- PIX_W, 8: pixel width in bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- threshold  in  PIX_W+3  magnitude threshold, sampled on the first accepted pixel of each frame
- in_data  in  PIX_W  input pixel
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  PIX_W  output pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data this cycle
- frame_done  out  1  one-cycle pulse on the handshake of the last output pixel of a frame

## Operation
- The datapath has two line buffers, each IMG_W x PIX_W. Together with a 3x3 window shift register they give the window centred on pixel (cx,cy).
- Stream positions: an incoming position counter col/row covers 0..IMG_W-1 and 0..IMG_H-1. The centre position lags the incoming position by IMG_W+1 positions.
- FSM states:
  - FILL: the first IMG_W+1 accepted pixels of a frame produce no output.
  - RUN: each step produces one output.
  - FLUSH: entered after the last input pixel (IMG_W*IMG_H-th). In FLUSH, in_ready is 0, and the block generates IMG_W+1 internal zero-pixel steps to drain the remaining outputs.
  - The last FLUSH step returns the FSM to FILL for the next frame.
- A step occurs in FILL/RUN on the input handshake, and in FLUSH when the output register is free.
- Gradient: Gx and Gy use the standard Sobel kernels in signed PIX_W+3 arithmetic. The magnitude is |Gx|+|Gy| at PIX_W+4 bits unsigned, with a maximum of 8*(2^PIX_W-1).
- Edge pixels (cx==0, cx==IMG_W-1, cy==0 or cy==IMG_H-1) output 0. This masks window wrap across lines and frames.
- Interior pixels output all-ones if magnitude > threshold_latched, else 0. Equality gives 0.
- Outputs per frame are exactly IMG_W*IMG_H, in raster order.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, frame_done=0. FSM goes to FILL, counters to 0, window contents to 0. Line buffer contents do not matter, because edge masking covers them.
- in_ready rises 1 cycle after rst_n deasserts.
- Output register:
  - out_data and out_valid are registered.
  - A RUN or FLUSH step loads them on the clock edge of the step.
  - Latency from the handshake of input (cx+1,cy+1) to out_valid is 1 cycle.
- Handshake rules:
  - in_ready = (state==FILL) || (state==RUN && (!out_valid || out_ready)).
  - out_data holds stable while out_valid && !out_ready.
  - Full throughput is 1 pixel per cycle when in_valid and out_ready stay high.
- Simultaneous events: in the same cycle, an output drain and a new step both proceed without a bubble.
- frame_done is asserted in the same cycle as the final out_valid && out_ready handshake.
- FLUSH-to-FILL transition: the first pixel of the next frame can be accepted in the cycle after the last FLUSH step. That pixel's handshake latches the new threshold.
- Reset mid-frame: partial frame state is discarded. The next accepted pixel is pixel (0,0) of a new frame.

## Configuration
- BORDER_DETECT_MAG_EN defined: interior pixels output the magnitude saturated to 2^PIX_W-1 instead of the binary result. In this mode threshold is ignored, and edge pixels still output 0.
- BORDER_DETECT_MAG_EN undefined: binary output as in Operation.

## Test plan
- Uniform frame, IMG_W=8, IMG_H=6, all pixels 0x80, threshold=127, continuous valid/ready -> 48 outputs, all 0x00; frame_done pulses once on output 48.
- Vertical step, 8x6 frame, x<4 = 0x00, x>=4 = 0xFF, threshold=127 -> columns 3 and 4 of rows 1..4 are 0xFF (magnitude 1020), all other outputs 0x00.
- Threshold boundary: same step frame with threshold=1020 -> all 0x00; threshold=1019 -> same result as the previous scenario.
- Back-pressure: step frame with out_ready toggled in a pseudo-random pattern and in_valid gapped -> output sequence identical to the continuous run, and out_data stable whenever it is stalled.
- Back-to-back frames: two 8x6 frames, the second inverted, with in_valid held high -> 96 outputs in order, two frame_done pulses, and no output lost across the FLUSH/FILL boundary.
- Reset mid-frame: rst_n asserted after 20 inputs, then a full step frame is sent -> outputs go to 0 immediately, and the following 48 outputs match the step-frame reference; with BORDER_DETECT_MAG_EN defined, the step columns read 0xFF (saturated).
